// File: rtl/serial_alu_if.sv
// Handshake and operand/result bundle for serial_alu.
// Carries the optional ovf flag when SERIAL_ALU_OVF_EN is defined.
interface serial_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [1:0]       aluctr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             e;
  logic             busy;
`ifdef SERIAL_ALU_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, c, aluctr, out_ready,
    input  in_ready, out_valid, d, e, busy, ovf
  );
  modport slave (
    input  in_valid, a, b, c, aluctr, out_ready,
    output in_ready, out_valid, d, e, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, c, aluctr, out_ready,
    input  in_ready, out_valid, d, e, busy
  );
  modport slave (
    input  in_valid, a, b, c, aluctr, out_ready,
    output in_ready, out_valid, d, e, busy
  );
`endif
endinterface

// File: rtl/serial_alu.sv
// Multi-cycle AND/OR/ADD/SUB ALU processing SLICE bits per clock with a registered carry.
// Optional signed-overflow output enabled by defining SERIAL_ALU_OVF_EN.
module serial_alu #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  serial_alu_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("serial_alu: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_nxt, d_q;
  logic [1:0]       op_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             e_q, in_ready_q, out_valid_q, busy_q;
  logic [SLICE-1:0] a_sl, b_sl, r_sl;
  logic             co_sl;
  int               base;
`ifdef SERIAL_ALU_OVF_EN
  logic             ovf_q;
  logic             b_msb;
`endif

  function automatic logic [SLICE:0] slice_op(input logic [1:0]       op,
                                              input logic [SLICE-1:0] x,
                                              input logic [SLICE-1:0] y,
                                              input logic             ci);
    logic [SLICE:0] s;
    case (op)
      OP_AND:  s = {1'b0, x & y};
      OP_OR:   s = {1'b0, x | y};
      OP_ADD:  s = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, ci};
      default: s = {1'b0, x} + {1'b0, ~y} + {{SLICE{1'b0}}, ci};
    endcase
    return s;
  endfunction

  // Operands agree in sign but the result does not: equivalent to carry-in ^ carry-out of the MSB.
  function automatic logic ovf_of(input logic xm, input logic ym, input logic rm);
    return (xm == ym) && (rm != xm);
  endfunction

  always_comb begin
    base              = int'(cnt) * SLICE;
    a_sl              = a_q[base +: SLICE];
    b_sl              = b_q[base +: SLICE];
    {co_sl, r_sl}     = slice_op(op_q, a_sl, b_sl, carry);
    acc_nxt           = acc;
    acc_nxt[base +: SLICE] = r_sl;
  end

`ifdef SERIAL_ALU_OVF_EN
  assign b_msb = (op_q == 2'b11) ? ~b_sl[SLICE-1] : b_sl[SLICE-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      d_q         <= '0;
      e_q         <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            op_q       <= bus.aluctr;
            carry      <= bus.c;
            cnt        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= co_sl;
          // Last slice: publish the merged accumulator, not the stale registered copy.
          if (cnt == CW'(N - 1)) begin
            d_q         <= acc_nxt;
            e_q         <= op_q[1] & co_sl;
`ifdef SERIAL_ALU_OVF_EN
            ovf_q       <= op_q[1] & ovf_of(a_sl[SLICE-1], b_msb, r_sl[SLICE-1]);
`endif
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.d         = d_q;
  assign bus.e         = e_q;
`ifdef SERIAL_ALU_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: a WIDTH=16/SLICE=4 instance plus a single-pass SLICE=16 instance.
module tb_serial_alu;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_alu_if #(.WIDTH(W)) bus0 ();
  serial_alu_if #(.WIDTH(W)) bus1 ();

  serial_alu #(.WIDTH(W), .SLICE(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus0));
  serial_alu #(.WIDTH(W), .SLICE(W)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int errs   = 0;
  int checks = 0;
  logic [W+1:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, e, d}
  function automatic logic [W+1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic c);
    logic [W:0]   s;
    logic [W-1:0] bb;
    int           sv;
    logic         v;
    if (op == 2'b00) return {2'b00, a & b};
    if (op == 2'b01) return {2'b00, a | b};
    bb = (op == 2'b11) ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    sv = int'($signed(a)) + int'($signed(bb)) + int'(c);
    v  = (sv > 32767) || (sv < -32768);
    return {v, s[W], s[W-1:0]};
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input int hold);
    int k;
    logic [W+1:0] exp;
    k = 0;
    while (!bus0.in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("in_ready_idle", bus0.in_ready, 1);
    bus0.a = a; bus0.b = b; bus0.c = c; bus0.aluctr = op; bus0.in_valid = 1'b1;
    sb.push_back(model(op, a, b, c));
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus0.a = W'($urandom); bus0.b = W'($urandom); bus0.c = ~c; bus0.aluctr = ~op;
    check("busy_run", bus0.busy, 1);
    check("in_ready_run", bus0.in_ready, 0);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!bus0.out_valid && k < 20);
    check("latency", k, 4);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int i = 0; i < hold; i++) begin
      bus0.in_valid = 1'b1; bus0.a = W'($urandom); bus0.b = W'($urandom);
      @(posedge clk); #1;
      check("hold_valid", bus0.out_valid, 1);
      check("hold_d", bus0.d, exp[W-1:0]);
      check("hold_in_ready", bus0.in_ready, 0);
    end
    bus0.in_valid = 1'b0;
    check("d", bus0.d, exp[W-1:0]);
    check("e", bus0.e, exp[W]);
`ifdef SERIAL_ALU_OVF_EN
    check("ovf", bus0.ovf, exp[W+1]);
`endif
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    check("valid_drop", bus0.out_valid, 0);
    check("in_ready_back", bus0.in_ready, 1);
    check("d_held", bus0.d, exp[W-1:0]);
  endtask

  initial begin
    int k;
    bus0.in_valid = 0; bus0.out_ready = 0; bus0.a = 0; bus0.b = 0; bus0.c = 0; bus0.aluctr = 0;
    bus1.in_valid = 0; bus1.out_ready = 0; bus1.a = 0; bus1.b = 0; bus1.c = 0; bus1.aluctr = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus0.in_ready, 1);
    check("rst_out_valid", bus0.out_valid, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_d", bus0.d, 0);
    check("rst_e", bus0.e, 0);
    check("rst1_in_ready", bus1.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'b10, 16'hFFFF, 16'h0001, 1'b0, 0);
    issue(2'b11, 16'h1234, 16'h0235, 1'b1, 0);
    issue(2'b11, 16'h0001, 16'h0002, 1'b1, 0);
    issue(2'b00, 16'hF0F0, 16'h3C3C, 1'b0, 0);
    issue(2'b01, 16'hF0F0, 16'h3C3C, 1'b0, 5);
    for (int i = 0; i < 8; i++)
      issue(2'(i), W'($urandom), W'($urandom), 1'($urandom), i % 3);

    // Abort while slice 2 is in progress
    bus0.a = 16'h1111; bus0.b = 16'h2222; bus0.c = 0; bus0.aluctr = 2'b10; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus0.out_valid, 0);
    check("abort_in_ready", bus0.in_ready, 1);
    check("abort_busy", bus0.busy, 0);
    check("abort_d", bus0.d, 0);
    check("abort_e", bus0.e, 0);
`ifdef SERIAL_ALU_OVF_EN
    check("abort_ovf", bus0.ovf, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b10, 16'h7FFF, 16'h0001, 1'b0, 0);

    // Single-pass instance
    bus1.a = 16'h7FFF; bus1.b = 16'h0001; bus1.c = 0; bus1.aluctr = 2'b10; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!bus1.out_valid && k < 20);
    check("s16_latency", k, 1);
    check("s16_d", bus1.d, 16'h8000);
    check("s16_e", bus1.e, 0);
`ifdef SERIAL_ALU_OVF_EN
    check("s16_ovf", bus1.ovf, 1);
`endif
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    check("s16_valid_drop", bus1.out_valid, 0);
    check("s16_in_ready", bus1.in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
